z80_bus_cycle: RTL and testbench
================================

// Module: z80_bus_cycle
// PURPOSE
//  Downstream of the z80 sequencer: turns its flat one-cycle bus requests (mem/io rd/wr, addr,
//  wdata) into Z80-style T-state pin cycles (T1/T2/Tw/T3[/T4]) with nMREQ/nIORQ/nRD/nWR/nM1/nRFSH
//  strobes. Returns captured read data to the sequencer via a valid/ready handshake.
//  One clk = one T-state; all outputs registered.
// PARAMETERS
//  IO_AUTO_WAIT  1  automatic wait states inserted in every I/O cycle (0..3)
// PORTS
//  clk           in   1   system clock; all logic on rising edge
//  reset         in   1   synchronous, active-high reset
//  req_valid     in   1   sequencer request strobe
//  req_ready     out  1   block can accept a request this cycle
//  req_mem_rd    in   1   memory read request
//  req_mem_wr    in   1   memory write request
//  req_io_rd     in   1   I/O read request
//  req_io_wr     in   1   I/O write request
//  req_m1        in   1   qualifies req_mem_rd as opcode fetch (M1 cycle)
//  req_addr      in   16  bus address
//  req_wdata     in   8   write data
//  refresh_addr  in   16  {I,R} address driven during M1 refresh states
//  rsp_valid     out  1   one-cycle pulse: cycle complete
//  rsp_rdata     out  8   captured read data (valid with rsp_valid on reads; holds otherwise)
//  rsp_err       out  1   one-cycle pulse: illegal request discarded
//  A             out  16  address pins
//  D_OUT         out  8   data pins out;  D_OE out 1 = drive D_OUT
//  D_IN          in   8   data pins in
//  nMREQ,nIORQ,nRD,nWR,nM1,nRFSH  out 1 each  active-low bus strobes
//  nWAIT         in   1   active-low wait request (used only with Z80_BUS_WAIT_EN)
// BEHAVIOUR
//  - Reset: state IDLE; all strobes 1; D_OE 0; A 0; D_OUT 0; rsp_valid/rsp_err 0; rsp_rdata 0;
//    req_ready 1. Reset mid-cycle aborts: strobes high the following cycle, no rsp_valid.
//  - States: IDLE, T1, T2, TA (auto wait), TW, T3, T4. req_ready=1 in IDLE and in the last state
//    of a cycle (T3; T4 for M1); accepting there goes straight to T1 (back-to-back, no idle gap).
//  - Request legality: exactly one of four op bits; req_m1 only with req_mem_rd. Otherwise
//    accepted, no bus activity, rsp_err pulses next cycle, state stays IDLE.
//  - A/D_OUT latched at acceptance, stable T1 through T3.
//  - Mem read: T1,T2,[TW*],T3; nMREQ=nRD=0 T1..T3; D_IN captured at end of T3;
//    rsp_valid next cycle. 3 clocks min.
//  - Mem write: T1,T2,[TW*],T3; nMREQ=0 T1..T3; D_OE=1 T1..T3; nWR=0 T2..T3 only.
//  - I/O rd/wr: T1,T2,TA x IO_AUTO_WAIT,[TW*],T3; nIORQ and nRD/nWR =0 T2..T3 (incl. waits);
//    D_OE=1 T1..T3 on writes. Read captured end of T3. 3+IO_AUTO_WAIT clocks min.
//  - M1: T1,T2,[TW*],T3,T4; nM1=nMREQ=nRD=0 T1..T2(+TW); D_IN captured end of T2 (last wait);
//    rsp_valid during T3; T3..T4 A=refresh_addr, nRFSH=0, nMREQ=0 in T3 only, nRD=1.
//  - Waits: nWAIT sampled at end of T2, each TA's last cycle and each TW; low -> (next) TW.
//    No wait limit. nWAIT never extends T3/T4.
//  - rsp_valid/rsp_err never both high; at most one pulse per accepted request, in order.
//  - req_valid while req_ready=0 is ignored (sequencer must hold it).
// CONFIGURATION
//  Z80_BUS_WAIT_EN defined: nWAIT honoured as above.
//  Undefined: nWAIT ignored, TW unreachable; fixed cycle lengths (3 mem, 3+IO_AUTO_WAIT io, 4 M1).
// TESTING
//  - Mem rd A=0x1234, D_IN=0xA5 -> nMREQ/nRD low 3 clks, rsp_valid clk 4 with rsp_rdata=0xA5.
//  - Mem wr A=0x8000 wdata=0x3C -> D_OE 3 clks, nWR low T2..T3 only, D_OUT=0x3C, rsp_valid after.
//  - IO rd A=0x00FE, IO_AUTO_WAIT=1 -> 4 clks, nIORQ low T2..T3, nMREQ never low.
//  - M1 fetch A=0x0000, refresh_addr=0x0105, D_IN=0x76 -> nM1 low T1..T2, rsp_rdata=0x76 in T3,
//    A=0x0105 with nRFSH low T3..T4.
//  - Z80_BUS_WAIT_EN: nWAIT low 2 clks during mem rd -> 2 TW inserted, cycle 5 clks.
//  - Illegal req (mem_rd+io_wr) -> rsp_err pulse, strobes stay high; reset in T2 -> strobes high next clk.

Source files
------------

// File: rtl/z80_bus_cycle.sv
// Converts one-cycle sequencer bus requests into Z80 T-state pin cycles with registered strobes.
// Define Z80_BUS_WAIT_EN to honour nWAIT; otherwise cycle lengths are fixed.
module z80_bus_cycle #(
    parameter int IO_AUTO_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mem_rd,
    input  logic        req_mem_wr,
    input  logic        req_io_rd,
    input  logic        req_io_wr,
    input  logic        req_m1,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [15:0] refresh_addr,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        nMREQ,
    output logic        nIORQ,
    output logic        nRD,
    output logic        nWR,
    output logic        nM1,
    output logic        nRFSH,
    input  logic        nWAIT,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_TA, S_TW, S_T3, S_T4
    } state_t;

    typedef enum logic [2:0] {
        OP_MRD, OP_MWR, OP_IORD, OP_IOWR, OP_M1
    } op_t;

    localparam int TA_LAST = (IO_AUTO_WAIT > 0) ? IO_AUTO_WAIT - 1 : 0;

    state_t      state_q, state_d;
    op_t         op_q, op_d, req_op;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        err_pend_q, err_pend_d;

    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [15:0] a_q, a_d;
    logic        doe_q, doe_d;
    logic        mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d;
    logic        rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic        m1_n_q, m1_n_d, rfsh_n_q, rfsh_n_d;

    logic [3:0]  ops;
    logic        req_legal, accept, illegal_acc, done, done_rd, wait_req;

`ifdef Z80_BUS_WAIT_EN
    assign wait_req = ~nWAIT;
`else
    logic unused_nwait;
    assign unused_nwait = nWAIT;
    assign wait_req     = 1'b0;
`endif

    // Legal: exactly one op bit, and the M1 qualifier only on memory reads.
    always_comb begin
        ops       = {req_mem_rd, req_mem_wr, req_io_rd, req_io_wr};
        req_legal = (ops != 4'd0) && ((ops & (ops - 4'd1)) == 4'd0) && (!req_m1 || req_mem_rd);
        if (req_m1)          req_op = OP_M1;
        else if (req_mem_rd) req_op = OP_MRD;
        else if (req_mem_wr) req_op = OP_MWR;
        else if (req_io_rd)  req_op = OP_IORD;
        else                 req_op = OP_IOWR;
        accept = req_valid && ready_q;
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        illegal_acc = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_T1:   state_d = S_T2;
            S_T2: begin
                if ((op_q == OP_IORD || op_q == OP_IOWR) && IO_AUTO_WAIT > 0) begin
                    state_d = S_TA;
                    cnt_d   = 2'(TA_LAST);
                end else begin
                    state_d = wait_req ? S_TW : S_T3;
                end
            end
            S_TA: begin
                if (cnt_q == 2'd0) state_d = wait_req ? S_TW : S_T3;
                else               cnt_d   = cnt_q - 2'd1;
            end
            S_TW:   state_d = wait_req ? S_TW : S_T3;
            S_T3:   state_d = (op_q == OP_M1) ? S_T4 : S_IDLE;
            S_T4:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            if (req_legal) begin
                state_d = S_T1;
                op_d    = req_op;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end else begin
                state_d     = S_IDLE;
                illegal_acc = 1'b1;
            end
        end
    end

    // Completion: end of T3 for plain cycles, end of T2/last TW for opcode fetch.
    // An illegal request accepted in the same cycle as a completion reports one cycle later.
    always_comb begin
        done_rd = 1'b0;
        done    = 1'b0;
        if (state_q == S_T3 && op_q != OP_M1) begin
            done    = 1'b1;
            done_rd = (op_q == OP_MRD) || (op_q == OP_IORD);
        end
        if (op_q == OP_M1 && (state_q == S_T2 || state_q == S_TW) && state_d == S_T3) begin
            done    = 1'b1;
            done_rd = 1'b1;
        end
        rsp_valid_d = done;
        rdata_d     = done_rd ? D_IN : rdata_q;
        rsp_err_d   = err_pend_q || (illegal_acc && !done);
        err_pend_d  = illegal_acc && done;
        ready_d     = (state_d == S_IDLE && !err_pend_d) ||
                      (state_d == S_T3 && op_d != OP_M1) || (state_d == S_T4);
    end

    // Pin decode for the state being entered, so pins are registered with it.
    always_comb begin
        mreq_n_d = 1'b1;
        iorq_n_d = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        m1_n_d   = 1'b1;
        rfsh_n_d = 1'b1;
        doe_d    = 1'b0;
        a_d      = addr_d;
        case (state_d)
            S_T1: begin
                case (op_d)
                    OP_MRD:  begin mreq_n_d = 1'b0; rd_n_d = 1'b0; end
                    OP_MWR:  begin mreq_n_d = 1'b0; doe_d = 1'b1; end
                    OP_IOWR: doe_d = 1'b1;
                    OP_M1:   begin mreq_n_d = 1'b0; rd_n_d = 1'b0; m1_n_d = 1'b0; end
                    default: ;
                endcase
            end
            S_T2, S_TA, S_TW, S_T3: begin
                case (op_d)
                    OP_MRD:  begin mreq_n_d = 1'b0; rd_n_d = 1'b0; end
                    OP_MWR:  begin mreq_n_d = 1'b0; wr_n_d = 1'b0; doe_d = 1'b1; end
                    OP_IORD: begin iorq_n_d = 1'b0; rd_n_d = 1'b0; end
                    OP_IOWR: begin iorq_n_d = 1'b0; wr_n_d = 1'b0; doe_d = 1'b1; end
                    OP_M1: begin
                        if (state_d == S_T3) begin
                            mreq_n_d = 1'b0;
                            rfsh_n_d = 1'b0;
                            a_d      = refresh_addr;
                        end else begin
                            mreq_n_d = 1'b0;
                            rd_n_d   = 1'b0;
                            m1_n_d   = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                rfsh_n_d = 1'b0;
                a_d      = refresh_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MRD;
            cnt_q       <= 2'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            err_pend_q  <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= 8'h00;
            a_q         <= 16'h0000;
            doe_q       <= 1'b0;
            mreq_n_q    <= 1'b1;
            iorq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            m1_n_q      <= 1'b1;
            rfsh_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_pend_q  <= err_pend_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rdata_q     <= rdata_d;
            a_q         <= a_d;
            doe_q       <= doe_d;
            mreq_n_q    <= mreq_n_d;
            iorq_n_q    <= iorq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            m1_n_q      <= m1_n_d;
            rfsh_n_q    <= rfsh_n_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign A         = a_q;
    assign D_OUT     = wdata_q;
    assign D_OE      = doe_q;
    assign nMREQ     = mreq_n_q;
    assign nIORQ     = iorq_n_q;
    assign nRD       = rd_n_q;
    assign nWR       = wr_n_q;
    assign nM1       = m1_n_q;
    assign nRFSH     = rfsh_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_z80_bus_cycle.sv
// Directed bench for z80_bus_cycle: per-T-state pin checks for each cycle type.
// Strobe vector order is {nMREQ, nIORQ, nRD, nWR, nM1, nRFSH}.
module tb_z80_bus_cycle;

    localparam int IO_AW = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic        req_mem_rd, req_mem_wr, req_io_rd, req_io_wr, req_m1;
    logic [15:0] req_addr, refresh_addr, A;
    logic [7:0]  req_wdata, rsp_rdata, D_OUT, D_IN;
    logic        rsp_valid, rsp_err, D_OE;
    logic        nMREQ, nIORQ, nRD, nWR, nM1, nRFSH, nWAIT;
    logic [2:0]  dbg_state;
    logic [5:0]  strobes;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign strobes = {nMREQ, nIORQ, nRD, nWR, nM1, nRFSH};

    z80_bus_cycle #(.IO_AUTO_WAIT(IO_AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mem_rd(req_mem_rd), .req_mem_wr(req_mem_wr),
        .req_io_rd(req_io_rd), .req_io_wr(req_io_wr), .req_m1(req_m1),
        .req_addr(req_addr), .req_wdata(req_wdata), .refresh_addr(refresh_addr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
        .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nM1(nM1), .nRFSH(nRFSH),
        .nWAIT(nWAIT), .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        req_valid  = 1'b0;
        req_mem_rd = 1'b0;
        req_mem_wr = 1'b0;
        req_io_rd  = 1'b0;
        req_io_wr  = 1'b0;
        req_m1     = 1'b0;
        req_addr   = 16'h0000;
        req_wdata  = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_req();
        nWAIT = 1'b1;
        D_IN = 8'h00;
        refresh_addr = 16'h0000;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (strobes !== 6'b111111) begin failures++; $display("FAIL reset_strobes: got %b expected 111111", strobes); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (D_OE !== 1'b0) begin failures++; $display("FAIL reset_doe: got %b expected 0", D_OE); end
        checks++; if (A !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h expected 0000", A); end
        checks++; if (D_OUT !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", D_OUT); end
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp: got valid=%b err=%b expected 0 0", rsp_valid, rsp_err); end
        checks++; if (rsp_rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h expected 00", rsp_rdata); end
        tick();
        checks++; if (strobes !== 6'b111111 || req_ready !== 1'b1) begin failures++; $display("FAIL idle_hold: got strobes=%b ready=%b expected 111111 1", strobes, req_ready); end
    endtask

    task automatic test_mem_rd();
        req_valid = 1'b1; req_mem_rd = 1'b1; req_addr = 16'h1234; D_IN = 8'h00;
        tick();
        clear_req();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) D_IN = 8'hA5;
            checks++; if (strobes !== 6'b010111) begin failures++; $display("FAIL mem_rd_strobes t%0d: got %b expected 010111", c, strobes); end
            checks++; if (A !== 16'h1234) begin failures++; $display("FAIL mem_rd_addr t%0d: got %h expected 1234", c, A); end
            checks++; if (req_ready !== (c == 3)) begin failures++; $display("FAIL mem_rd_ready t%0d: got %b expected %b", c, req_ready, (c == 3)); end
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mem_rd_early_valid t%0d: got %b expected 0", c, rsp_valid); end
            tick();
        end
        D_IN = 8'h00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) begin failures++; $display("FAIL mem_rd_rsp: got valid=%b data=%h expected 1 a5", rsp_valid, rsp_rdata); end
        checks++; if (strobes !== 6'b111111) begin failures++; $display("FAIL mem_rd_end_strobes: got %b expected 111111", strobes); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'hA5) begin failures++; $display("FAIL mem_rd_pulse: got valid=%b data=%h expected 0 a5", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_mem_wr();
        logic [5:0] exp_s;
        req_valid = 1'b1; req_mem_wr = 1'b1; req_addr = 16'h8000; req_wdata = 8'h3C;
        tick();
        clear_req();
        for (int c = 1; c <= 3; c++) begin
            exp_s = (c == 1) ? 6'b011111 : 6'b011011;
            checks++; if (strobes !== exp_s) begin failures++; $display("FAIL mem_wr_strobes t%0d: got %b expected %b", c, strobes, exp_s); end
            checks++; if (D_OE !== 1'b1 || D_OUT !== 8'h3C) begin failures++; $display("FAIL mem_wr_data t%0d: got oe=%b d=%h expected 1 3c", c, D_OE, D_OUT); end
            checks++; if (A !== 16'h8000) begin failures++; $display("FAIL mem_wr_addr t%0d: got %h expected 8000", c, A); end
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || D_OE !== 1'b0) begin failures++; $display("FAIL mem_wr_done: got valid=%b oe=%b expected 1 0", rsp_valid, D_OE); end
        checks++; if (rsp_rdata !== 8'hA5) begin failures++; $display("FAIL mem_wr_rdata_hold: got %h expected a5", rsp_rdata); end
        tick();
    endtask

    task automatic test_io_rd();
        logic [5:0] exp_s;
        req_valid = 1'b1; req_io_rd = 1'b1; req_addr = 16'h00FE; D_IN = 8'h00;
        tick();
        clear_req();
        for (int c = 1; c <= 3 + IO_AW; c++) begin
            exp_s = (c == 1) ? 6'b111111 : 6'b100111;
            if (c == 3 + IO_AW) D_IN = 8'h5A;
            checks++; if (strobes !== exp_s) begin failures++; $display("FAIL io_rd_strobes t%0d: got %b expected %b", c, strobes, exp_s); end
            checks++; if (A !== 16'h00FE) begin failures++; $display("FAIL io_rd_addr t%0d: got %h expected 00fe", c, A); end
            checks++; if (req_ready !== (c == 3 + IO_AW)) begin failures++; $display("FAIL io_rd_ready t%0d: got %b expected %b", c, req_ready, (c == 3 + IO_AW)); end
            tick();
        end
        D_IN = 8'h00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A) begin failures++; $display("FAIL io_rd_rsp: got valid=%b data=%h expected 1 5a", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_io_wr();
        logic [5:0] exp_s;
        req_valid = 1'b1; req_io_wr = 1'b1; req_addr = 16'h0042; req_wdata = 8'h99;
        tick();
        clear_req();
        for (int c = 1; c <= 3 + IO_AW; c++) begin
            exp_s = (c == 1) ? 6'b111111 : 6'b101011;
            checks++; if (strobes !== exp_s) begin failures++; $display("FAIL io_wr_strobes t%0d: got %b expected %b", c, strobes, exp_s); end
            checks++; if (D_OE !== 1'b1 || D_OUT !== 8'h99) begin failures++; $display("FAIL io_wr_data t%0d: got oe=%b d=%h expected 1 99", c, D_OE, D_OUT); end
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A) begin failures++; $display("FAIL io_wr_done: got valid=%b data=%h expected 1 5a", rsp_valid, rsp_rdata); end
        tick();
    endtask

    task automatic test_m1();
        req_valid = 1'b1; req_mem_rd = 1'b1; req_m1 = 1'b1; req_addr = 16'h0000;
        refresh_addr = 16'h0105; D_IN = 8'h00;
        tick();
        clear_req();
        checks++; if (strobes !== 6'b010101 || A !== 16'h0000) begin failures++; $display("FAIL m1_t1: got strobes=%b a=%h expected 010101 0000", strobes, A); end
        tick();
        D_IN = 8'h76;
        checks++; if (strobes !== 6'b010101 || A !== 16'h0000) begin failures++; $display("FAIL m1_t2: got strobes=%b a=%h expected 010101 0000", strobes, A); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL m1_t2_valid: got %b expected 0", rsp_valid); end
        tick();
        D_IN = 8'hFF;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h76) begin failures++; $display("FAIL m1_t3_rsp: got valid=%b data=%h expected 1 76", rsp_valid, rsp_rdata); end
        checks++; if (strobes !== 6'b011110 || A !== 16'h0105) begin failures++; $display("FAIL m1_t3_refresh: got strobes=%b a=%h expected 011110 0105", strobes, A); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL m1_t3_ready: got %b expected 0", req_ready); end
        tick();
        checks++; if (strobes !== 6'b111110 || A !== 16'h0105) begin failures++; $display("FAIL m1_t4_refresh: got strobes=%b a=%h expected 111110 0105", strobes, A); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 8'h76) begin failures++; $display("FAIL m1_t4_rsp: got valid=%b ready=%b data=%h expected 0 1 76", rsp_valid, req_ready, rsp_rdata); end
        tick();
        checks++; if (strobes !== 6'b111111 || rsp_valid !== 1'b0) begin failures++; $display("FAIL m1_idle: got strobes=%b valid=%b expected 111111 0", strobes, rsp_valid); end
        D_IN = 8'h00;
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_mem_rd = 1'b1; req_addr = 16'h1111; D_IN = 8'h00;
        tick();
        clear_req();
        tick();
        tick();
        D_IN = 8'hC3;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_t3_ready: got %b expected 1", req_ready); end
        req_valid = 1'b1; req_mem_wr = 1'b1; req_addr = 16'h2222; req_wdata = 8'h55;
        tick();
        clear_req();
        D_IN = 8'h00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC3) begin failures++; $display("FAIL b2b_rd_rsp: got valid=%b data=%h expected 1 c3", rsp_valid, rsp_rdata); end
        checks++; if (strobes !== 6'b011111 || A !== 16'h2222) begin failures++; $display("FAIL b2b_wr_t1: got strobes=%b a=%h expected 011111 2222", strobes, A); end
        checks++; if (D_OE !== 1'b1 || D_OUT !== 8'h55) begin failures++; $display("FAIL b2b_wr_data: got oe=%b d=%h expected 1 55", D_OE, D_OUT); end
        tick();
        checks++; if (strobes !== 6'b011011 || rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_wr_t2: got strobes=%b valid=%b expected 011011 0", strobes, rsp_valid); end
        tick();
        checks++; if (strobes !== 6'b011011 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_wr_t3: got strobes=%b ready=%b expected 011011 1", strobes, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || strobes !== 6'b111111 || rsp_rdata !== 8'hC3) begin failures++; $display("FAIL b2b_wr_done: got valid=%b strobes=%b data=%h expected 1 111111 c3", rsp_valid, strobes, rsp_rdata); end
        tick();
    endtask

    task automatic test_illegal();
        for (int p = 0; p < 3; p++) begin
            req_valid = 1'b1; req_addr = 16'hABCD;
            case (p)
                0: begin req_mem_rd = 1'b1; req_io_wr = 1'b1; end
                1: begin req_io_rd = 1'b1; req_m1 = 1'b1; end
                default: ;
            endcase
            tick();
            clear_req();
            checks++; if (rsp_err !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL illegal_err p%0d: got err=%b valid=%b expected 1 0", p, rsp_err, rsp_valid); end
            checks++; if (strobes !== 6'b111111 || D_OE !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL illegal_bus p%0d: got strobes=%b oe=%b ready=%b expected 111111 0 1", p, strobes, D_OE, req_ready); end
            tick();
            checks++; if (rsp_err !== 1'b0 || strobes !== 6'b111111) begin failures++; $display("FAIL illegal_pulse p%0d: got err=%b strobes=%b expected 0 111111", p, rsp_err, strobes); end
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_mem_rd = 1'b1; req_addr = 16'h4444;
        tick();
        clear_req();
        tick();
        checks++; if (strobes !== 6'b010111) begin failures++; $display("FAIL rst_mid_t2: got %b expected 010111", strobes); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (strobes !== 6'b111111 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_abort: got strobes=%b ready=%b expected 111111 1", strobes, req_ready); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (rsp_valid !== 1'b0 || strobes !== 6'b111111) begin failures++; $display("FAIL rst_mid_quiet c%0d: got valid=%b strobes=%b expected 0 111111", c, rsp_valid, strobes); end
            tick();
        end
    endtask

`ifdef Z80_BUS_WAIT_EN
    task automatic test_wait();
        req_valid = 1'b1; req_mem_rd = 1'b1; req_addr = 16'h1234; D_IN = 8'h00;
        tick();
        clear_req();
        for (int c = 1; c <= 5; c++) begin
            nWAIT = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            if (c == 5) D_IN = 8'hE7;
            checks++; if (strobes !== 6'b010111 || rsp_valid !== 1'b0) begin failures++; $display("FAIL wait_strobes t%0d: got strobes=%b valid=%b expected 010111 0", c, strobes, rsp_valid); end
            checks++; if (req_ready !== (c == 5)) begin failures++; $display("FAIL wait_ready t%0d: got %b expected %b", c, req_ready, (c == 5)); end
            tick();
        end
        nWAIT = 1'b1;
        D_IN = 8'h00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hE7) begin failures++; $display("FAIL wait_rsp: got valid=%b data=%h expected 1 e7", rsp_valid, rsp_rdata); end
        tick();
    endtask
`else
    task automatic test_wait_ignored();
        req_valid = 1'b1; req_mem_rd = 1'b1; req_addr = 16'h1234; D_IN = 8'h00;
        tick();
        clear_req();
        nWAIT = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) D_IN = 8'hE7;
            checks++; if (strobes !== 6'b010111) begin failures++; $display("FAIL nowait_strobes t%0d: got %b expected 010111", c, strobes); end
            tick();
        end
        nWAIT = 1'b1;
        D_IN = 8'h00;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hE7) begin failures++; $display("FAIL nowait_rsp: got valid=%b data=%h expected 1 e7", rsp_valid, rsp_rdata); end
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_mem_rd();
        test_mem_wr();
        test_io_rd();
        test_io_wr();
        test_m1();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
`ifdef Z80_BUS_WAIT_EN
        test_wait();
`else
        test_wait_ignored();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
